seg7_scan_ctrl: RTL

Parametrised time-multiplexed driver for a bank of common-anode 7-segment displays; successor to the fixed 4-digit scanner. Supports NUM_DIGITS digits, per-digit decimal point and enable mask, and PWM brightness control. A double-buffered load handshake makes new values take effect only on a frame boundary, so the display never tears. Sits between the datapath (counters, measurement results) and the board display pins.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_scan_timer.sv | 51 +++++
 rtl/seg7_scan_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment decode for the 7-segment scan controller.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot prescaler, digit index and per-slot PWM gate; brightness is sampled
// at each slot start so a change never alters a slot already running.
module seg7_scan_timer #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 16384,
  parameter int PWM_BITS    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PWM_BITS-1:0]           brightness,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          frame_end,
  output logic                          pwm_on
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [PRE_W-1:0]    prescaler_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [PWM_BITS-1:0] bright_reg;
  logic                slot_start;
  logic                slot_wrap;
  logic [PWM_BITS-1:0] bright_eff;

  assign slot_start = (prescaler_reg == '0);
  assign slot_wrap  = (prescaler_reg == PRE_W'(REFRESH_DIV - 1));
  assign frame_end  = slot_wrap && (idx_reg == IDX_W'(NUM_DIGITS - 1));

  // The first cycle of a slot already uses the freshly sampled brightness.
  assign bright_eff = slot_start ? brightness : bright_reg;
  assign pwm_on     = (prescaler_reg[PRE_W-1 -: PWM_BITS] < bright_eff);
  assign idx        = idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_reg <= '0;
      idx_reg       <= '0;
      bright_reg    <= '0;
    end else begin
      prescaler_reg <= slot_wrap ? '0 : prescaler_reg + 1'b1;
      if (slot_wrap) begin
        idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
      end
      if (slot_start) begin
        bright_reg <= brightness;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment driver with frame-synchronous double-buffered load.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 16384,
  parameter int PWM_BITS    = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int   IDX_W = $clog2(NUM_DIGITS);
  localparam logic AL    = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] digits_buf_reg, digits_act_reg;
  logic [NUM_DIGITS-1:0]   dp_buf_reg, dp_act_reg;
  logic [NUM_DIGITS-1:0]   en_buf_reg, en_act_reg;
  logic                    pending_reg, pending_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  seg_t                    seg_reg, seg_next;
  logic                    frame_tick_reg;

  logic [IDX_W-1:0]      idx;
  logic                  frame_end;
  logic                  pwm_on;
  logic [3:0]            digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] vis;
  logic [NUM_DIGITS-1:0] one_hot;
  logic                  lit;

  seg7_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .PWM_BITS   (PWM_BITS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .brightness(brightness),
    .idx       (idx),
    .frame_end (frame_end),
    .pwm_on    (pwm_on)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // zero_run[i]: every digit j >= i is a zero with its dp off.
  logic [NUM_DIGITS:1] zero_run;
  assign zero_run[NUM_DIGITS] = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = digits_act_reg[4*gi +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_first
        assign vis[gi] = en_act_reg[gi];
      end else begin : g_rest
        assign zero_run[gi] = (digit_arr[gi] == 4'h0) && !dp_act_reg[gi] && zero_run[gi+1];
        assign vis[gi]      = en_act_reg[gi] && !zero_run[gi];
      end
`else
      assign vis[gi] = en_act_reg[gi];
`endif
    end
  endgenerate

  always_comb begin
    one_hot  = NUM_DIGITS'(1) << idx;
    lit      = pwm_on && vis[idx];
    an_next  = lit ? ~one_hot : {NUM_DIGITS{1'b1}};
    seg_next = lit ? {~dp_act_reg[idx], hex_to_seg(digit_arr[idx])} : SEG_OFF;
    if (!AL) begin
      an_next  = ~an_next;
      seg_next = ~seg_next;
    end
  end

  // A load on the boundary cycle refills the buffer after the old one commits.
  always_comb begin
    pending_next = pending_reg;
    if (load) begin
      pending_next = 1'b1;
    end else if (frame_end) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_buf_reg <= '0;
      dp_buf_reg     <= '0;
      en_buf_reg     <= '0;
      digits_act_reg <= '0;
      dp_act_reg     <= '0;
      en_act_reg     <= '0;
      pending_reg    <= 1'b0;
      an_reg         <= {NUM_DIGITS{AL}};
      seg_reg        <= {8{AL}};
      frame_tick_reg <= 1'b0;
    end else begin
      if (load) begin
        digits_buf_reg <= digits_in;
        dp_buf_reg     <= dp_in;
        en_buf_reg     <= en_in;
      end
      if (frame_end && pending_reg) begin
        digits_act_reg <= digits_buf_reg;
        dp_act_reg     <= dp_buf_reg;
        en_act_reg     <= en_buf_reg;
      end
      pending_reg    <= pending_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_tick_reg <= frame_end;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign pending    = pending_reg;
  assign frame_tick = frame_tick_reg;

endmodule
